// File: rtl/reservoir_plant.sv
// ---------------------------------------------------------------------------
// reservoir_plant
//
// Cycle-based behavioural model of a water reservoir. It is closed in a loop
// with the reservoir flow controller. Each cycle it does three things:
//   - adds the commanded inflow (fr1/fr2/fr3/dfr) to a saturating level
//     register and subtracts the outflow demand;
//   - reports the direction of the net flow as a trend;
//   - produces thermometer-coded level sensors for the controller.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   fr1..fr3   flow commands, each adds R1/R2/R3 per cycle
//   dfr        supplemental flow command, adds RD per cycle
//   demand     outflow drawn from the reservoir this cycle (DEM_W bits)
//   s[2:0]     level sensors s[3:1]: bit k-1 is sensor k, thermometer coded
//   level      current reservoir level
//   trend      2'b00 HOLD, 2'b01 RISING, 2'b10 FALLING
//   overflow   high for one cycle after the level clamps at LVL_MAX
//   underflow  high for one cycle after the level clamps at 0
//
// Optional feature, selected by the macro SENSOR_HYST_EN:
//   When the macro is defined, each sensor sets at level >= THk and clears
//   only at level < THk-HYST. Between those limits it holds its value.
//   When the macro is undefined, each sensor is a plain threshold compare
//   and HYST has no effect.
// ---------------------------------------------------------------------------
module reservoir_plant #(
  parameter int LVL_W      = 8,
  parameter int LVL_MAX    = 255,
  parameter int INIT_LEVEL = 0,
  parameter int TH1        = 64,
  parameter int TH2        = 128,
  parameter int TH3        = 192,
  parameter int R1         = 4,
  parameter int R2         = 4,
  parameter int R3         = 4,
  parameter int RD         = 8,
  parameter int DEM_W      = 6,
  parameter int HYST       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fr1,
  input  logic             fr2,
  input  logic             fr3,
  input  logic             dfr,
  input  logic [DEM_W-1:0] demand,
  output logic [2:0]       s,
  output logic [LVL_W-1:0] level,
  output logic [1:0]       trend,
  output logic             overflow,
  output logic             underflow
);

  // Three extra bits hold the full level + inflow - demand range without
  // wrapping. One bit covers the sign and two bits cover the carry headroom.
  localparam int RAW_W = LVL_W + 3;

  // A zero hysteresis band reduces the hold/clear logic to a plain compare.
  // That is why one sensor function serves both builds.
`ifdef SENSOR_HYST_EN
  localparam int HYST_EFF = HYST;
`else
  localparam int HYST_EFF = 0;
`endif

  localparam logic signed [RAW_W-1:0] MAX_S = RAW_W'(LVL_MAX);

  typedef enum logic [1:0] {
    TR_HOLD    = 2'b00,
    TR_RISING  = 2'b01,
    TR_FALLING = 2'b10
  } trend_e;

  logic [LVL_W-1:0]        level_q, level_d;
  logic [2:0]              s_q, s_d;
  trend_e                  trend_q, trend_d;
  logic                    overflow_q, overflow_d;
  logic                    underflow_q, underflow_d;

  logic signed [RAW_W-1:0] inflow;
  logic signed [RAW_W-1:0] net;
  logic signed [RAW_W-1:0] raw;

  // A sensor sets at or above its threshold and clears below the band.
  // Inside the band it keeps its previous value.
  function automatic logic sense_bit(input logic [LVL_W-1:0] lvl,
                                     input int th,
                                     input logic prev);
    int lv;
    lv = int'(lvl);
    if (lv >= th)                 return 1'b1;
    else if (lv < th - HYST_EFF)  return 1'b0;
    else                          return prev;
  endfunction

  // Net flow, the saturating level update, and the clamp pulses.
  always_comb begin
    inflow      = '0;
    net         = '0;
    raw         = '0;
    level_d     = level_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;

    if (fr1) inflow = inflow + RAW_W'(R1);
    if (fr2) inflow = inflow + RAW_W'(R2);
    if (fr3) inflow = inflow + RAW_W'(R3);
    if (dfr) inflow = inflow + RAW_W'(RD);

    net = inflow - $signed({{(RAW_W-DEM_W){1'b0}}, demand});
    raw = $signed({3'b000, level_q}) + net;

    if (raw > MAX_S) begin
      level_d    = LVL_W'(LVL_MAX);
      overflow_d = 1'b1;
    end else if (raw < 0) begin
      level_d     = '0;
      underflow_d = 1'b1;
    end else begin
      level_d = raw[LVL_W-1:0];
    end
  end

  // The trend follows the sign of the net flow before clamping. A clamped
  // step therefore still reports its direction.
  always_comb begin
    trend_d = TR_HOLD;
    if (net > 0)      trend_d = TR_RISING;
    else if (net < 0) trend_d = TR_FALLING;
  end

  // Sensors read the level register rather than level_d. This makes s lag
  // level by exactly one cycle.
  always_comb begin
    s_d    = '0;
    s_d[0] = sense_bit(level_q, TH1, s_q[0]);
    s_d[1] = sense_bit(level_q, TH2, s_q[1]);
    s_d[2] = sense_bit(level_q, TH3, s_q[2]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q     <= LVL_W'(INIT_LEVEL);
      s_q         <= '0;
      trend_q     <= TR_HOLD;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      level_q     <= level_d;
      s_q         <= s_d;
      trend_q     <= trend_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign level     = level_q;
  assign s         = s_q;
  assign trend     = trend_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_reservoir_plant.sv
// ---------------------------------------------------------------------------
// tb_reservoir_plant
//
// Directed bench for reservoir_plant in its default build, where the sensors
// are plain threshold compares. A table of hand-computed vectors walks the
// level through these cases:
//   - fill and drain;
//   - each sensor threshold;
//   - the overflow and underflow clamps;
//   - zero net flow with a nonzero inflow.
// A hand-written sequence then checks an asynchronous reset in the middle of
// a clock period, followed by the synchronous release.
// ---------------------------------------------------------------------------
module tb_reservoir_plant;

  logic       clk;
  logic       rst_n;
  logic       fr1, fr2, fr3, dfr;
  logic [5:0] demand;
  logic [2:0] s;
  logic [7:0] level;
  logic [1:0] trend;
  logic       overflow, underflow;

  int checks;
  int failures;

  localparam logic [1:0] H = 2'b00;
  localparam logic [1:0] R = 2'b01;
  localparam logic [1:0] F = 2'b10;

  typedef struct {
    logic [3:0] cmd;     // {fr1, fr2, fr3, dfr}
    logic [5:0] dem;
    logic [7:0] lvl;
    logic [2:0] sens;
    logic [1:0] tr;
    logic       ov;
    logic       un;
  } vec_t;

  vec_t vecs[$];

  reservoir_plant dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fr1       (fr1),
    .fr2       (fr2),
    .fr3       (fr3),
    .dfr       (dfr),
    .demand    (demand),
    .s         (s),
    .level     (level),
    .trend     (trend),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [3:0] cmd, input logic [5:0] dem,
                              input logic [7:0] lvl, input logic [2:0] sens,
                              input logic [1:0] tr, input logic ov,
                              input logic un);
    vec_t v;
    v.cmd = cmd; v.dem = dem; v.lvl = lvl; v.sens = sens;
    v.tr = tr; v.ov = ov; v.un = un;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic [7:0] lvl,
                          input logic [2:0] sens, input logic [1:0] tr,
                          input logic ov, input logic un);
    checkOutput({tag, " level"}, 32'(level), 32'(lvl));
    checkOutput({tag, " s"}, 32'(s), 32'(sens));
    checkOutput({tag, " trend"}, 32'(trend), 32'(tr));
    checkOutput({tag, " overflow"}, 32'(overflow), 32'(ov));
    checkOutput({tag, " underflow"}, 32'(underflow), 32'(un));
  endtask

  task automatic applyStimulus(input logic [3:0] cmd, input logic [5:0] dem);
    {fr1, fr2, fr3, dfr} = cmd;
    demand = dem;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    applyStimulus(4'b0000, 6'd0);

    // Fill at inflow 12: the level climbs and s lags by one cycle.
    vecs.push_back(mk(4'b1110, 6'd0,  8'd12,  3'b000, R, 0, 0));
    vecs.push_back(mk(4'b1110, 6'd0,  8'd24,  3'b000, R, 0, 0));
    vecs.push_back(mk(4'b1110, 6'd0,  8'd36,  3'b000, R, 0, 0));
    vecs.push_back(mk(4'b1110, 6'd0,  8'd48,  3'b000, R, 0, 0));
    vecs.push_back(mk(4'b1110, 6'd0,  8'd60,  3'b000, R, 0, 0));
    vecs.push_back(mk(4'b1110, 6'd0,  8'd72,  3'b000, R, 0, 0));
    vecs.push_back(mk(4'b0000, 6'd12, 8'd60,  3'b001, F, 0, 0));
    vecs.push_back(mk(4'b0000, 6'd0,  8'd60,  3'b000, H, 0, 0));
    // Climb at inflow 20 through all three thresholds.
    vecs.push_back(mk(4'b1111, 6'd0,  8'd80,  3'b000, R, 0, 0));
    vecs.push_back(mk(4'b1111, 6'd0,  8'd100, 3'b001, R, 0, 0));
    vecs.push_back(mk(4'b1111, 6'd0,  8'd120, 3'b001, R, 0, 0));
    vecs.push_back(mk(4'b1111, 6'd0,  8'd140, 3'b001, R, 0, 0));
    vecs.push_back(mk(4'b1111, 6'd0,  8'd160, 3'b011, R, 0, 0));
    vecs.push_back(mk(4'b1111, 6'd0,  8'd180, 3'b011, R, 0, 0));
    vecs.push_back(mk(4'b1111, 6'd0,  8'd200, 3'b011, R, 0, 0));
    vecs.push_back(mk(4'b1111, 6'd0,  8'd220, 3'b111, R, 0, 0));
    vecs.push_back(mk(4'b1111, 6'd0,  8'd240, 3'b111, R, 0, 0));
    vecs.push_back(mk(4'b1111, 6'd10, 8'd250, 3'b111, R, 0, 0));
    // Overflow clamp held for three cycles, then released.
    vecs.push_back(mk(4'b1111, 6'd0,  8'd255, 3'b111, R, 1, 0));
    vecs.push_back(mk(4'b1111, 6'd0,  8'd255, 3'b111, R, 1, 0));
    vecs.push_back(mk(4'b1111, 6'd0,  8'd255, 3'b111, R, 1, 0));
    vecs.push_back(mk(4'b0000, 6'd0,  8'd255, 3'b111, H, 0, 0));
    // Drain at maximum demand; s walks back down the thermometer.
    vecs.push_back(mk(4'b0000, 6'd63, 8'd192, 3'b111, F, 0, 0));
    vecs.push_back(mk(4'b0000, 6'd63, 8'd129, 3'b111, F, 0, 0));
    vecs.push_back(mk(4'b0000, 6'd63, 8'd66,  3'b011, F, 0, 0));
    vecs.push_back(mk(4'b0000, 6'd63, 8'd3,   3'b001, F, 0, 0));
    vecs.push_back(mk(4'b1000, 6'd2,  8'd5,   3'b000, R, 0, 0));
    // Underflow clamp for one cycle, then hold.
    vecs.push_back(mk(4'b0000, 6'd10, 8'd0,   3'b000, F, 0, 1));
    vecs.push_back(mk(4'b0000, 6'd0,  8'd0,   3'b000, H, 0, 0));
    // dfr alone, then zero net flow with a nonzero inflow.
    vecs.push_back(mk(4'b0001, 6'd0,  8'd8,   3'b000, R, 0, 0));
    vecs.push_back(mk(4'b0101, 6'd12, 8'd8,   3'b000, H, 0, 0));
    // Exact TH1 boundary: 64 sets s[1], 63 clears it.
    vecs.push_back(mk(4'b1111, 6'd0,  8'd28,  3'b000, R, 0, 0));
    vecs.push_back(mk(4'b1111, 6'd0,  8'd48,  3'b000, R, 0, 0));
    vecs.push_back(mk(4'b1101, 6'd0,  8'd64,  3'b000, R, 0, 0));
    vecs.push_back(mk(4'b0000, 6'd0,  8'd64,  3'b001, H, 0, 0));
    vecs.push_back(mk(4'b0000, 6'd1,  8'd63,  3'b001, F, 0, 0));
    vecs.push_back(mk(4'b0000, 6'd0,  8'd63,  3'b000, H, 0, 0));

    // Reset values, sampled while reset is still asserted.
    #12;
    checkAll("reset", 8'd0, 3'b000, H, 1'b0, 1'b0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].cmd, vecs[i].dem);
      stepCycle();
      checkAll($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].sens,
               vecs[i].tr, vecs[i].ov, vecs[i].un);
    end

    // Step up from 63 at inflow 12, then reset asynchronously mid-period.
    applyStimulus(4'b1110, 6'd0);
    for (int k = 1; k <= 4; k++) begin
      stepCycle();
      checkOutput($sformatf("prereset%0d level", k), 32'(level),
                  32'(63 + 12 * k));
    end
    checkAll("prereset", 8'd111, 3'b001, R, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    checkAll("async_reset", 8'd0, 3'b000, H, 1'b0, 1'b0);

    // Release between edges; the next rising edge resumes from zero.
    @(negedge clk);
    rst_n = 1'b1;
    stepCycle();
    checkAll("post_reset", 8'd12, 3'b000, R, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reservoir_plant.md
Name: reservoir_plant

Overview:
- Cycle-based behavioural model of the water reservoir driven by the reservoir flow controller.
- Consumes the controller's flow-rate commands fr1/fr2/fr3/dfr and an external demand (outflow) value.
- Integrates the net flow into a saturating level register and produces the thermometer-coded level sensors s[3:1] that feed back into the controller.
- Closes the loop so the controller/plant pair can be simulated together and also synthesised for an FPGA demo.

Parameters:
- LVL_W, 8, level register width in bits.
- LVL_MAX, 255, maximum level, clamp ceiling (must be <= 2^LVL_W-1).
- INIT_LEVEL, 0, level loaded on reset.
- TH1, 64, level at or above which s[1] asserts.
- TH2, 128, level at or above which s[2] asserts.
- TH3, 192, level at or above which s[3] asserts (TH1 < TH2 < TH3 required).
- R1, 4, inflow per cycle contributed by fr1.
- R2, 4, inflow per cycle contributed by fr2.
- R3, 4, inflow per cycle contributed by fr3.
- RD, 8, extra inflow per cycle contributed by dfr.
- DEM_W, 6, demand input width.
- HYST, 8, sensor hysteresis band (used only with SENSOR_HYST_EN).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- fr1  input  1  flow command 1 from controller.
- fr2  input  1  flow command 2 from controller.
- fr3  input  1  flow command 3 from controller.
- dfr  input  1  supplemental flow command from controller.
- demand  input  DEM_W  outflow drawn from reservoir this cycle.
- s  output  3  level sensors [3:1], thermometer code.
- level  output  LVL_W  current reservoir level.
- trend  output  2  00 HOLD, 01 RISING, 10 FALLING (11 unused).
- overflow  output  1  one-cycle pulse when the clamp at LVL_MAX engaged.
- underflow  output  1  one-cycle pulse when the clamp at 0 engaged.

Behaviour:
- Interface: one clock, clk; reset rst_n asynchronous, active-low.
- Reset (async assert, sync release at next clk edge): level=INIT_LEVEL, s=3'b000, trend=HOLD, overflow=0, underflow=0.
- inflow = fr1*R1 + fr2*R2 + fr3*R3 + dfr*RD. Inputs are additive and independent; no legality check on the combination.
- raw = level + inflow - demand, computed signed in LVL_W+3 bits; no intermediate wrap.
- Clamping, registered each cycle:
  - raw > LVL_MAX: level<=LVL_MAX, overflow<=1.
  - raw < 0: level<=0, underflow<=1.
  - otherwise level<=raw and both pulses <=0.
- overflow and underflow are mutually exclusive; each is high for exactly the cycle following the clamping edge.
- Sensors are registered from the updated level register, so s lags level by exactly one cycle.
  - s[1]=(level>=TH1), s[2]=(level>=TH2), s[3]=(level>=TH3).
  - Legal values only: 000, 001, 011, 111.
- Trend FSM, evaluated on net = inflow - demand (pre-clamp):
  - net>0 -> RISING; net<0 -> FALLING; net==0 -> HOLD.
  - A clamped step still reports its direction: RISING at full, FALLING at empty, even though level is unchanged.
  - All transitions are direct, one cycle; no intermediate states.
- Boundary cases:
  - At level==LVL_MAX with net>0: level holds, overflow pulses every cycle the condition persists.
  - Same rule applies at 0 with net<0 for underflow.
  - Input changes take effect on the next rising edge only.
- Reset mid-operation: outputs return to reset values immediately (async). There is no memory of the pre-reset level.

Optional Feature:
- Macro: SENSOR_HYST_EN.
- Defined: each s[k] sets when level>=THk and clears only when level<THk-HYST; otherwise it holds its previous value. Thermometer ordering is still guaranteed provided TH(k+1)-HYST > THk.
- Undefined: pure threshold compare as described in Behaviour; HYST is ignored.

Test Plan:
- Reset, demand=0, fr1=fr2=fr3=1, dfr=0 (inflow 12) -> level 12,24,...,72 on clocks 1..6; s=001 on clock 7; trend=RISING throughout.
- From level 72, all commands 0, demand=12 -> level 60 on next clock; s=000 one clock later; trend=FALLING.
- Level 250, fr1=fr2=fr3=dfr=1 (inflow 20), demand=0 -> level=255, overflow pulses; held 3 cycles -> overflow high 3 cycles, level stays 255, s=111.
- Level 5, all commands 0, demand=10 -> level=0, underflow one cycle; then demand=0 -> trend=HOLD, underflow=0.
- Level 100 stepping with inflow 12: assert rst_n=0 between edges -> level=0, s=000, trend=HOLD immediately, before the next clk edge.
- With SENSOR_HYST_EN: level rises to 68 (s[1]=1), falls to 60 -> s[1] stays 1; falls to 52 -> s[1]=0 one cycle later.
